output_argmax: RTL and testbench



---
 rtl/output_argmax.sv | 141 ++++++++++++++
 tb/tb_output_argmax.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/output_argmax.sv
// Argmax stage: captures the final-layer score vector, scans it one score
// per clock and holds the winning index/value under a valid/ack handshake.
module output_argmax #(
  parameter int NUM_CLASSES    = 10,
  parameter int INTEGER_WIDTH  = 8,
  parameter int FRACTION_WIDTH = 8,
  parameter int INDEX_WIDTH    =
    (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int SW = INTEGER_WIDTH + FRACTION_WIDTH
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            scores_ready,
  input  logic [NUM_CLASSES-1:0][SW-1:0]  scores,
  input  logic                            class_ack,
  output logic [INDEX_WIDTH-1:0]          class_index,
  output logic [SW-1:0]                   class_score,
  output logic                            class_valid,
  output logic                            busy,
  output logic                            overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST =
    INDEX_WIDTH'(NUM_CLASSES - 1);

  state_t                           state_q, state_d;
  logic [NUM_CLASSES-1:0][SW-1:0]   cap_q, cap_d;
  logic [SW-1:0]                    best_val_q, best_val_d;
  logic [INDEX_WIDTH-1:0]           best_idx_q, best_idx_d;
  logic [INDEX_WIDTH-1:0]           cnt_q, cnt_d;
  logic [INDEX_WIDTH-1:0]           idx_q, idx_d;
  logic [SW-1:0]                    score_q, score_d;
  logic                             valid_q, valid_d;
  logic                             overrun_q, overrun_d;

  logic                             load;
  logic                             take;
  logic [SW-1:0]                    cand;
  logic [SW-1:0]                    win_val;
  logic [INDEX_WIDTH-1:0]           win_idx;

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    score_d    = score_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    load       = 1'b0;
    cand       = cap_q[cnt_q];
    // Strictly greater only, so ties keep the lowest index.
    take       = $signed(cand) > $signed(best_val_q);
    win_val    = take ? cand : best_val_q;
    win_idx    = take ? cnt_q : best_idx_q;

    unique case (state_q)
      IDLE: begin
        if (scores_ready) load = 1'b1;
      end
      SCAN: begin
        if (scores_ready) overrun_d = 1'b1;
        best_val_d = win_val;
        best_idx_d = win_idx;
        if (cnt_q == LAST) begin
          idx_d   = win_idx;
          score_d = win_val;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (class_ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
          if (scores_ready) load = 1'b1;
        end else if (scores_ready) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      cap_d      = scores;
      best_val_d = scores[0];
      best_idx_d = '0;
      cnt_d      = INDEX_WIDTH'(1);
      if (NUM_CLASSES == 1) begin
        idx_d   = '0;
        score_d = scores[0];
        valid_d = 1'b1;
        state_d = HOLD;
      end else begin
        valid_d = 1'b0;
        state_d = SCAN;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cap_q      <= '0;
      best_val_q <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      score_q    <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      score_q    <= score_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign class_index = idx_q;
  assign class_score = score_q;
  assign class_valid = valid_q;
  assign busy        = (state_q != IDLE);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_output_argmax.sv
// Directed bench for output_argmax: default 10-class build plus a
// single-class build sharing clock and reset.
module tb_output_argmax;

  typedef logic [9:0][15:0] vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        scores_ready = 1'b0;
  vec_t        scores = '0;
  logic        class_ack = 1'b0;
  logic [3:0]  class_index;
  logic [15:0] class_score;
  logic        class_valid;
  logic        busy;
  logic        overrun;

  logic        ready1 = 1'b0;
  logic [0:0][15:0] scores1 = '0;
  logic        ack1 = 1'b0;
  logic [0:0]  index1;
  logic [15:0] score1;
  logic        valid1;
  logic        busy1;
  logic        overrun1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  output_argmax dut (
    .clock(clock), .reset(reset),
    .scores_ready(scores_ready), .scores(scores),
    .class_ack(class_ack), .class_index(class_index),
    .class_score(class_score), .class_valid(class_valid),
    .busy(busy), .overrun(overrun)
  );

  output_argmax #(.NUM_CLASSES(1)) dut1 (
    .clock(clock), .reset(reset),
    .scores_ready(ready1), .scores(scores1),
    .class_ack(ack1), .class_index(index1),
    .class_score(score1), .class_valid(valid1),
    .busy(busy1), .overrun(overrun1)
  );

  function automatic logic [15:0] fx(input real r);
    return 16'($rtoi(r * 256.0));
  endfunction

  function automatic vec_t mk(
    input real a, b, c, d, e, f, g, h, i, j);
    vec_t v;
    v[0] = fx(a); v[1] = fx(b); v[2] = fx(c); v[3] = fx(d);
    v[4] = fx(e); v[5] = fx(f); v[6] = fx(g); v[7] = fx(h);
    v[8] = fx(i); v[9] = fx(j);
    return v;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input vec_t v);
    scores = v;
    scores_ready = 1'b1;
    tick();
    scores_ready = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!class_valid && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  task automatic ack_once();
    class_ack = 1'b1;
    tick();
    class_ack = 1'b0;
  endtask

  task automatic run(input string tag, input vec_t v,
                     input int eidx, input logic [15:0] escr);
    int lat;
    start(v);
    wait_valid(lat);
    chk({tag, "_lat"}, lat, 9);
    chk({tag, "_idx"}, class_index, eidx);
    chk({tag, "_score"}, class_score, escr);
    ack_once();
    chk({tag, "_cleared"}, class_valid, 0);
  endtask

  initial begin
    int lat;
    vec_t va, vn, vt;
    va = mk(0.5, -1.0, 2.25, 0.0, 1.0, 3.0, -0.25, 0.75, 2.9, 0.1);
    vn = mk(-4.0, -2.5, -3.0, -5.0, -6.0, -7.0, -3.5, -4.5, -6.5, -8.0);
    vt = mk(0.0, 0.0, 1.5, 0.0, 0.0, 0.0, 0.0, 1.5, 0.0, 0.0);

    tick();
    tick();
    chk("rst_valid", class_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", class_index, 0);
    chk("rst_score", class_score, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    tick();

    // single-class build: valid on the capture edge
    scores1[0] = fx(-1.5);
    ready1 = 1'b1;
    tick();
    ready1 = 1'b0;
    chk("n1_valid", valid1, 1);
    chk("n1_idx", index1, 0);
    chk("n1_score", score1, fx(-1.5));
    chk("n1_busy", busy1, 1);
    ack1 = 1'b1;
    tick();
    ack1 = 1'b0;
    chk("n1_cleared", valid1, 0);
    chk("n1_overrun", overrun1, 0);

    // ack held high throughout; ignored until HOLD
    class_ack = 1'b1;
    start(va);
    chk("t1_busy_cap", busy, 1);
    chk("t1_valid_cap", class_valid, 0);
    wait_valid(lat);
    chk("t1_lat", lat, 9);
    chk("t1_idx", class_index, 5);
    chk("t1_score", class_score, fx(3.0));
    chk("t1_busy_hold", busy, 1);
    tick();
    class_ack = 1'b0;
    chk("t1_valid_ack", class_valid, 0);
    chk("t1_busy_ack", busy, 0);
    chk("t1_idx_kept", class_index, 5);

    run("neg", vn, 1, fx(-2.5));
    run("tie", vt, 2, fx(1.5));
    run("max0", mk(5.0, 1.0, 2.0, 0.0, -1.0, 4.9, 3.0, 0.0, 1.0, 2.0),
        0, fx(5.0));
    run("max9", mk(1.0, 1.0, 2.0, 0.0, -1.0, 4.9, 3.0, 0.0, 1.0, 5.0),
        9, fx(5.0));

    // long hold, then ack together with a new pulse
    start(va);
    wait_valid(lat);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_valid", class_valid, 1);
      chk("hold_idx", class_index, 5);
      chk("hold_score", class_score, fx(3.0));
    end
    class_ack = 1'b1;
    scores = vn;
    scores_ready = 1'b1;
    tick();
    class_ack = 1'b0;
    scores_ready = 1'b0;
    chk("b2b_valid", class_valid, 0);
    chk("b2b_busy", busy, 1);
    wait_valid(lat);
    chk("b2b_lat", lat, 9);
    chk("b2b_idx", class_index, 1);
    chk("b2b_score", class_score, fx(-2.5));
    chk("b2b_overrun", overrun, 0);
    ack_once();

    // dropped pulse mid-scan
    start(va);
    tick(); tick(); tick();
    start(vt);
    wait_valid(lat);
    chk("ovr_valid", class_valid, 1);
    chk("ovr_idx", class_index, 5);
    chk("ovr_score", class_score, fx(3.0));
    chk("ovr_flag", overrun, 1);
    ack_once();
    chk("ovr_idle_valid", class_valid, 0);
    chk("ovr_idle_busy", busy, 0);
    chk("ovr_sticky", overrun, 1);

    // reset mid-scan
    start(vn);
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_valid", class_valid, 0);
    chk("mrst_idx", class_index, 0);
    chk("mrst_score", class_score, 0);
    chk("mrst_overrun", overrun, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("mrst_no_valid", class_valid, 0);
    end
    run("post_rst", vt, 2, fx(1.5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
